// File: rtl/mem_resp.sv
// Memory responder: req/wr/addr/rdy target with programmable read/write latency.
// Optional `MEM_RESP_STATS_EN adds completed-read/write counters on rd_cnt/wr_cnt.
module mem_resp #(
    parameter int AW     = 13,
    parameter int DW     = 64,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          wr,
    input  logic [63:0]   addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rdy,
    output logic          err,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt
);

    localparam int RL = (RD_LAT < 1) ? 1 : RD_LAT;
    localparam int WL = (WR_LAT < 1) ? 1 : WR_LAT;
    localparam logic [31:0] RL_M1 = 32'(RL - 1);
    localparam logic [31:0] WL_M1 = 32'(WL - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [1:0]    state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic          oor_q;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic          rdy_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    logic          cap;
    logic          commit;
    logic [AW-1:0] c_idx;
    logic          c_oor;
    logic          c_wr;
    logic [DW-1:0] c_wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cap   = 1'b1;
                    cnt_d = wr ? WL_M1 : RL_M1;
                    if (cnt_d == 32'd0) begin
                        state_d = ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q <= 32'd1) begin
                    cnt_d   = 32'd0;
                    state_d = ACK;
                    commit  = 1'b1;
                end
            end
            ACK:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A zero-wait access commits on the capture edge, so it uses the live inputs.
    assign c_idx   = cap ? addr[AW-1:0] : addr_q;
    assign c_oor   = cap ? (|addr[63:AW]) : oor_q;
    assign c_wr    = cap ? wr : wr_q;
    assign c_wdata = cap ? wdata : wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                addr_q  <= addr[AW-1:0];
                oor_q   <= |addr[63:AW];
                wr_q    <= wr;
                wdata_q <= wdata;
            end
            rdy_q <= (state_q == ACK);
            err_q <= (state_q == ACK) && oor_q;
            if (commit && !c_wr) begin
                rdata_q <= c_oor ? '0 : mem[c_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_wr && !c_oor) begin
            mem[c_idx] <= c_wdata;
        end
    end

    assign rdata = rdata_q;
    assign rdy   = rdy_q;
    assign err   = err_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (state_q == ACK) begin
            if (wr_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = 32'd0;
    assign wr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_resp.sv
// Directed self-checking bench for mem_resp (RD_LAT=2, WR_LAT=5).
// Counter expectations follow MEM_RESP_STATS_EN.
module tb_mem_resp;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rdy;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int total = 0;
    int bad   = 0;

`ifdef MEM_RESP_STATS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    mem_resp #(.AW(13), .DW(64), .RD_LAT(2), .WR_LAT(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rdy    (rdy),
        .err    (err),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one transaction from IDLE; lat = edges from sampling to rdy seen.
    task automatic txn(input logic w, input logic [63:0] a,
                       input logic [63:0] d, output int lat,
                       output logic [63:0] rd, output logic e);
        lat = -1;
        rd  = '0;
        e   = 1'b0;
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rdy) begin
                lat = n;
                rd  = rdata;
                e   = err;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [63:0] rd;
    logic        e;
    int          nrdy;
    int          k1, k2;
    logic [63:0] d1, d2;
    logic        sawrdy;

    initial begin
        rst = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        #1;
        chk("reset_rdy", 64'(rdy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_rdcnt", 64'(rd_cnt), 64'd0);
        chk("reset_wrcnt", 64'(wr_cnt), 64'd0);
        do_reset();

        // 1: write then read back
        txn(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, lat, rd, e);
        chk("t1_wr_lat", 64'(lat), 64'd5);
        chk("t1_wr_err", 64'(e), 64'd0);
        txn(1'b0, 64'h10, 64'h0, lat, rd, e);
        chk("t1_rd_lat", 64'(lat), 64'd2);
        chk("t1_rd_data", rd, 64'hDEAD_BEEF_0123_4567);
        chk("t1_rd_err", 64'(e), 64'd0);

        // 2: back-to-back reads with req held
        txn(1'b1, 64'h0, 64'hA0A0_0000_0000_00A0, lat, rd, e);
        txn(1'b1, 64'h1, 64'hA1A1_0000_0000_00A1, lat, rd, e);
        nrdy = 0; k1 = -1; k2 = -1; d1 = '0; d2 = '0;
        req = 1'b1; wr = 1'b0; addr = 64'h0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (rdy) begin
                nrdy++;
                if (nrdy == 1) begin
                    k1 = k; d1 = rdata; addr = 64'h1;
                end else if (nrdy == 2) begin
                    k2 = k; d2 = rdata; req = 1'b0;
                end
            end
        end
        req = 1'b0;
        chk("t2_nrdy", 64'(nrdy), 64'd2);
        chk("t2_first", 64'(k1), 64'd2);
        chk("t2_spacing", 64'(k2 - k1), 64'd4);
        chk("t2_d0", d1, 64'hA0A0_0000_0000_00A0);
        chk("t2_d1", d2, 64'hA1A1_0000_0000_00A1);

        // 3: read-modify-write increment
        do_reset();
        txn(1'b1, 64'h1FFF, 64'd7, lat, rd, e);
        txn(1'b0, 64'h1FFF, 64'h0, lat, rd, e);
        chk("t3_rd7", rd, 64'd7);
        txn(1'b1, 64'h1FFF, rd + 64'd1, lat, rd, e);
        txn(1'b0, 64'h1FFF, 64'h0, lat, rd, e);
        chk("t3_rd8", rd, 64'd8);
        chk("t3_wrcnt", 64'(wr_cnt), ST ? 64'd2 : 64'd0);
        chk("t3_rdcnt", 64'(rd_cnt), ST ? 64'd2 : 64'd0);

        // 4: out of range
        txn(1'b1, 64'h2000, 64'h55, lat, rd, e);
        chk("t4_wr_err", 64'(e), 64'd1);
        chk("t4_wr_lat", 64'(lat), 64'd5);
        txn(1'b0, 64'h2000, 64'h0, lat, rd, e);
        chk("t4_rd_err", 64'(e), 64'd1);
        chk("t4_rd_data", rd, 64'd0);
        txn(1'b0, 64'h0, 64'h0, lat, rd, e);
        chk("t4_mem0", rd, 64'hA0A0_0000_0000_00A0);
        chk("t4_mem0_err", 64'(e), 64'd0);
        chk("t4_wrcnt", 64'(wr_cnt), ST ? 64'd3 : 64'd0);
        chk("t4_rdcnt", 64'(rd_cnt), ST ? 64'd4 : 64'd0);

        // 5: reset mid-write
        txn(1'b1, 64'h5, 64'h1234, lat, rd, e);
        sawrdy = 1'b0;
        req = 1'b1; wr = 1'b1; addr = 64'h5; wdata = 64'hAA;
        @(posedge clk);
        @(posedge clk); #1; sawrdy |= rdy;
        @(posedge clk); #1; sawrdy |= rdy;
        rst = 1'b0; req = 1'b0;
        #1;
        chk("t5_norey", 64'(sawrdy | rdy), 64'd0);
        chk("t5_err", 64'(err), 64'd0);
        chk("t5_rdata", rdata, 64'd0);
        chk("t5_rdcnt", 64'(rd_cnt), 64'd0);
        chk("t5_wrcnt", 64'(wr_cnt), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 64'h5, 64'h0, lat, rd, e);
        chk("t5_prior", rd, 64'h1234);

        // 6: inputs changed mid-transaction
        txn(1'b1, 64'h21, 64'h11, lat, rd, e);
        lat = -1;
        req = 1'b1; wr = 1'b1; addr = 64'h20; wdata = 64'h77;
        @(posedge clk);
        @(posedge clk); #1;
        addr = 64'h21; wdata = 64'h99; wr = 1'b0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rdy) begin
                lat = n;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        chk("t6_lat", 64'(lat), 64'd5);
        txn(1'b0, 64'h20, 64'h0, lat, rd, e);
        chk("t6_addr20", rd, 64'h77);
        txn(1'b0, 64'h21, 64'h0, lat, rd, e);
        chk("t6_addr21", rd, 64'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
